// File: rtl/mul_drv_pkg.sv
// Shared types and width helpers for the multiplier operand driver.
// The MUL_DRV_ERRSUM_EN build option is handled in the modules that import this package.
package mul_drv_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, HOLD} drv_state_t;

   function automatic int prod_w(input int width);
      return 2 * width;
   endfunction

   function automatic int err_w(input int width);
      return 2 * width + 1;
   endfunction

endpackage

// File: rtl/mul_err_stats.sv
// Saturating error statistics: result count, mismatch count, max |err|.
// MUL_DRV_ERRSUM_EN adds a saturating sum of |err| and a stat_clr input.
module mul_err_stats
   import mul_drv_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sample,
   input  logic [2*WIDTH:0]         err,
`ifdef MUL_DRV_ERRSUM_EN
   input  logic                     stat_clr,
   output logic [CNT_W+2*WIDTH-1:0] stat_err_sum,
`endif
   output logic [CNT_W-1:0]         stat_count,
   output logic [CNT_W-1:0]         stat_mismatch,
   output logic [2*WIDTH-1:0]       stat_max_abs
);

   localparam int PW = prod_w(WIDTH);
   localparam int EW = err_w(WIDTH);

   logic [PW-1:0] abs_err;
   logic          clr;

   // err never reaches -2^PW, so its magnitude always fits in PW bits
   always_comb begin
      abs_err = err[PW-1:0];
      if (err[EW-1])
         abs_err = ~err[PW-1:0] + 1'b1;
   end

`ifdef MUL_DRV_ERRSUM_EN
   localparam int SW = CNT_W + PW;
   logic [SW:0] sum_ext;

   assign sum_ext = {1'b0, stat_err_sum} + {{(CNT_W+1){1'b0}}, abs_err};
   assign clr     = rst | stat_clr;

   always_ff @(posedge clk) begin
      if (clr)
         stat_err_sum <= '0;
      else if (sample)
         stat_err_sum <= sum_ext[SW] ? '1 : sum_ext[SW-1:0];
   end
`else
   assign clr = rst;
`endif

   always_ff @(posedge clk) begin
      if (clr) begin
         stat_count    <= '0;
         stat_mismatch <= '0;
         stat_max_abs  <= '0;
      end else if (sample) begin
         if (stat_count != '1)
            stat_count <= stat_count + 1'b1;
         if (err != '0 && stat_mismatch != '1)
            stat_mismatch <= stat_mismatch + 1'b1;
         if (abs_err > stat_max_abs)
            stat_max_abs <= abs_err;
      end
   end

endmodule

// File: rtl/mul_operand_driver.sv
// Drives operand pairs into a combinational approximate multiplier, samples after SETTLE cycles,
// and returns product plus signed error (exact - approx). MUL_DRV_ERRSUM_EN adds stat_err_sum/stat_clr.
module mul_operand_driver
   import mul_drv_pkg::*;
#(
   parameter int WIDTH  = 6,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     op_valid,
   output logic                     op_ready,
   input  logic [WIDTH-1:0]         op_a,
   input  logic [WIDTH-1:0]         op_b,
   output logic [WIDTH-1:0]         mul_in1,
   output logic [WIDTH-1:0]         mul_in2,
   input  logic [2*WIDTH-1:0]       mul_out,
   input  logic                     mul_overflow,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [2*WIDTH-1:0]       res_prod,
   output logic [2*WIDTH:0]         res_err,
   output logic                     res_ovf,
`ifdef MUL_DRV_ERRSUM_EN
   input  logic                     stat_clr,
   output logic [CNT_W+2*WIDTH-1:0] stat_err_sum,
`endif
   output logic [CNT_W-1:0]         stat_count,
   output logic [CNT_W-1:0]         stat_mismatch,
   output logic [2*WIDTH-1:0]       stat_max_abs
);

   localparam int         PW         = prod_w(WIDTH);
   localparam int         EW         = err_w(WIDTH);
   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
   // SETTLE of 0 or 1 samples in the cycle right after the operands are registered
   localparam bit         DIRECT     = (SETTLE <= 1);

   drv_state_t    state;
   logic [3:0]    settle_cnt;
   logic [PW-1:0] exact;
   logic [EW-1:0] err_now;
   logic          sample;

   assign exact   = {{WIDTH{1'b0}}, mul_in1} * {{WIDTH{1'b0}}, mul_in2};
   assign err_now = {1'b0, exact} - {1'b0, mul_out};
   assign sample  = (state == SAMPLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         op_ready   <= 1'b1;
         res_valid  <= 1'b0;
         mul_in1    <= '0;
         mul_in2    <= '0;
         res_prod   <= '0;
         res_err    <= '0;
         res_ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (op_valid && op_ready) begin
                  mul_in1    <= op_a;
                  mul_in2    <= op_b;
                  settle_cnt <= SETTLE_CNT;
                  op_ready   <= 1'b0;
                  state      <= DIRECT ? SAMPLE : DRIVE;
               end
            end
            DRIVE: begin
               settle_cnt <= settle_cnt - 1'b1;
               if (settle_cnt == 4'd2)
                  state <= SAMPLE;
            end
            SAMPLE: begin
               res_prod  <= mul_out;
               res_ovf   <= mul_overflow;
               res_err   <= err_now;
               res_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  op_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mul_err_stats #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) u_stats (
      .clk          (clk),
      .rst          (rst),
      .sample       (sample),
      .err          (err_now),
`ifdef MUL_DRV_ERRSUM_EN
      .stat_clr     (stat_clr),
      .stat_err_sum (stat_err_sum),
`endif
      .stat_count   (stat_count),
      .stat_mismatch(stat_mismatch),
      .stat_max_abs (stat_max_abs)
   );

endmodule

// File: tb/tb_mul_operand_driver.sv
// Bench for mul_operand_driver: instance a (SETTLE=2, CNT_W=32), instance b (SETTLE=0, CNT_W=4).
// Optional MUL_DRV_ERRSUM_EN ports are connected and checked when the macro is defined.
module tb_mul_operand_driver;

   typedef struct packed {
      logic [11:0] prod;
      logic [12:0] err;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   exp_t sb_a[$];
   exp_t sb_b[$];

   // instance a signals
   logic        op_valid_a = 0, op_ready_a, res_valid_a, res_ready_a = 0, res_ovf_a, ovf_a = 0;
   logic [5:0]  opa_a = 0, opb_a = 0, mul_in1_a, mul_in2_a;
   logic [11:0] mul_out_a, res_prod_a, stat_max_abs_a, bias_a = 0;
   logic [12:0] res_err_a;
   logic [31:0] stat_count_a, stat_mismatch_a;
   // instance b signals
   logic        op_valid_b = 0, op_ready_b, res_valid_b, res_ready_b = 0, res_ovf_b;
   logic        mul_ovf_b = 0;
   logic [5:0]  opa_b = 0, opb_b = 0, mul_in1_b, mul_in2_b;
   logic [11:0] mul_out_b, res_prod_b, stat_max_abs_b;
   logic [12:0] res_err_b;
   logic [3:0]  stat_count_b, stat_mismatch_b;
`ifdef MUL_DRV_ERRSUM_EN
   logic        stat_clr_a = 0, stat_clr_b = 0;
   logic [43:0] err_sum_a;
   logic [15:0] err_sum_b;
`endif

   // stub multipliers: a subtracts a programmable bias, b drops 1 when both operands are odd
   function automatic logic [11:0] stub_b(input logic [5:0] x, input logic [5:0] y);
      logic [11:0] p;
      p = {6'b0, x} * {6'b0, y};
      if (x[0] && y[0]) p = p - 12'd1;
      return p;
   endfunction

   assign mul_out_a = ({6'b0, mul_in1_a} * {6'b0, mul_in2_a}) - bias_a;
   assign mul_out_b = stub_b(mul_in1_b, mul_in2_b);

   mul_operand_driver #(.WIDTH(6), .SETTLE(2), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .op_valid(op_valid_a), .op_ready(op_ready_a),
      .op_a(opa_a), .op_b(opb_a), .mul_in1(mul_in1_a), .mul_in2(mul_in2_a),
      .mul_out(mul_out_a), .mul_overflow(ovf_a), .res_valid(res_valid_a),
      .res_ready(res_ready_a), .res_prod(res_prod_a), .res_err(res_err_a),
      .res_ovf(res_ovf_a),
`ifdef MUL_DRV_ERRSUM_EN
      .stat_clr(stat_clr_a), .stat_err_sum(err_sum_a),
`endif
      .stat_count(stat_count_a), .stat_mismatch(stat_mismatch_a),
      .stat_max_abs(stat_max_abs_a)
   );

   mul_operand_driver #(.WIDTH(6), .SETTLE(0), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .op_valid(op_valid_b), .op_ready(op_ready_b),
      .op_a(opa_b), .op_b(opb_b), .mul_in1(mul_in1_b), .mul_in2(mul_in2_b),
      .mul_out(mul_out_b), .mul_overflow(mul_ovf_b), .res_valid(res_valid_b),
      .res_ready(res_ready_b), .res_prod(res_prod_b), .res_err(res_err_b),
      .res_ovf(res_ovf_b),
`ifdef MUL_DRV_ERRSUM_EN
      .stat_clr(stat_clr_b), .stat_err_sum(err_sum_b),
`endif
      .stat_count(stat_count_b), .stat_mismatch(stat_mismatch_b),
      .stat_max_abs(stat_max_abs_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_a(input int a, input int b, input int bias, input bit ovf);
      exp_t e;
      int ex, ap, d;
      for (int k = 0; k < 20 && !op_ready_a; k++) @(negedge clk);
      check("op_ready_a before send", op_ready_a, 1);
      ex = a * b;
      ap = ex - bias;
      d  = ex - ap;
      e.prod = ap[11:0];
      e.err  = d[12:0];
      e.ovf  = ovf;
      sb_a.push_back(e);
      opa_a = a[5:0];
      opb_a = b[5:0];
      bias_a = bias[11:0];
      ovf_a = ovf;
      op_valid_a = 1;
      @(negedge clk);
      op_valid_a = 0;
   endtask

   task automatic recv_a(output int lat);
      exp_t e;
      lat = 1;
      while (lat < 20 && !res_valid_a) begin
         @(negedge clk);
         lat++;
      end
      check("res_valid_a", res_valid_a, 1);
      if (sb_a.size() > 0) begin
         e = sb_a.pop_front();
         check("res_prod_a", res_prod_a, e.prod);
         check("res_err_a", res_err_a, e.err);
         check("res_ovf_a", res_ovf_a, e.ovf);
      end
   endtask

   task automatic ack_a();
      res_ready_a = 1;
      @(negedge clk);
      res_ready_a = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, sent, got, last, n_odd, ex, ap, d, a, b;
      exp_t e;

      // reset state
      repeat (2) @(negedge clk);
      check("rst op_ready_a", op_ready_a, 1);
      check("rst res_valid_a", res_valid_a, 0);
      check("rst mul_in1_a", mul_in1_a, 0);
      check("rst mul_in2_a", mul_in2_a, 0);
      check("rst res_prod_a", res_prod_a, 0);
      check("rst res_err_a", res_err_a, 0);
      check("rst res_ovf_a", res_ovf_a, 0);
      check("rst stat_count_a", stat_count_a, 0);
      check("rst stat_max_abs_a", stat_max_abs_a, 0);
      check("rst op_ready_b", op_ready_b, 1);
      rst = 0;
      @(negedge clk);

      // exact product, latency
      send_a(7, 9, 0, 0);
      recv_a(lat);
      check("latency settle2", lat, 3);
      check("count after op1", stat_count_a, 1);
      check("mismatch after op1", stat_mismatch_a, 0);
      ack_a();

      // +1 error with overflow flag, then hold with res_ready low
      send_a(63, 63, 1, 1);
      recv_a(lat);
      check("count after op2", stat_count_a, 2);
      check("mismatch after op2", stat_mismatch_a, 1);
      check("max_abs after op2", stat_max_abs_a, 1);
      for (int k = 0; k < 5; k++) begin
         opa_a = 6'(k + 1);
         opb_a = 6'(k + 2);
         op_valid_a = 1;
         @(negedge clk);
         check("hold res_valid", res_valid_a, 1);
         check("hold op_ready", op_ready_a, 0);
         check("hold res_prod", res_prod_a, 12'd3968);
         check("hold res_err", res_err_a, 13'd1);
      end
      op_valid_a = 0;
      ack_a();
      check("op_ready after ack", op_ready_a, 1);
      check("res_valid after ack", res_valid_a, 0);
      check("mul_in1 ignored pulses", mul_in1_a, 6'd63);

      // -2 error
      send_a(5, 5, -2, 0);
      recv_a(lat);
      check("count after op3", stat_count_a, 3);
      check("mismatch after op3", stat_mismatch_a, 2);
      check("max_abs after op3", stat_max_abs_a, 2);
      ack_a();

`ifdef MUL_DRV_ERRSUM_EN
      check("err_sum_a", err_sum_a, 3);
      stat_clr_a = 1;
      @(negedge clk);
      stat_clr_a = 0;
      check("clr count", stat_count_a, 0);
      check("clr mismatch", stat_mismatch_a, 0);
      check("clr max_abs", stat_max_abs_a, 0);
      check("clr err_sum", err_sum_a, 0);
`endif

      // instance b: SETTLE=0 back-to-back, counter saturation
      res_ready_b = 1;
      sent = 0; got = 0; last = 0; n_odd = 0;
      for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
         @(negedge clk);
         if (res_valid_b) begin
            if (sb_b.size() > 0) begin
               e = sb_b.pop_front();
               check("b res_prod", res_prod_b, e.prod);
               check("b res_err", res_err_b, e.err);
            end
            if (got > 0) check("b result spacing", cyc - last, 3);
            last = cyc;
            got++;
         end
         if (op_ready_b) begin
            if (sent < 20) begin
               a = int'($urandom_range(0, 63));
               b = int'($urandom_range(0, 63));
               if (sent == 0) begin a = 63; b = 63; end
               ex = a * b;
               ap = ex - (((a % 2) == 1 && (b % 2) == 1) ? 1 : 0);
               d  = ex - ap;
               if (d != 0) n_odd++;
               e.prod = ap[11:0];
               e.err  = d[12:0];
               e.ovf  = 1'b0;
               sb_b.push_back(e);
               opa_b = a[5:0];
               opb_b = b[5:0];
               op_valid_b = 1;
               sent++;
            end else begin
               op_valid_b = 0;
            end
         end
      end
      op_valid_b = 0;
      check("b results received", got, 20);
      check("b stat_count saturates", stat_count_b, 4'd15);
      check("b stat_mismatch", stat_mismatch_b, (n_odd > 15) ? 15 : n_odd);
      check("b stat_max_abs", stat_max_abs_b, (n_odd > 0) ? 1 : 0);
`ifdef MUL_DRV_ERRSUM_EN
      check("b err_sum", err_sum_b, n_odd);
`endif

      // reset in DRIVE aborts the operation
      send_a(10, 11, 0, 0);
      rst = 1;
      @(negedge clk);
      rst = 0;
      sb_a.delete();
      check("abort op_ready", op_ready_a, 1);
      check("abort res_valid", res_valid_a, 0);
      check("abort mul_in1", mul_in1_a, 0);
      check("abort stat_count", stat_count_a, 0);
      repeat (6) @(negedge clk);
      check("post-abort res_valid", res_valid_a, 0);
      check("post-abort stat_count", stat_count_a, 0);

      send_a(3, 4, 0, 0);
      recv_a(lat);
      check("post-abort latency", lat, 3);
      check("post-abort count", stat_count_a, 1);
      ack_a();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mul_operand_driver.md
Name: mul_operand_driver

Overview:
- Sequential driver/checker for the driver end of the if_multiplier interface. The multiplier under test sits on the opposite end.
- Accepts operand pairs over a valid/ready stream and applies them to the combinational approximate multiplier.
- Waits a programmable settle time, samples the product, and compares it against an exact product.
- Returns the product and its signed error over a second valid/ready stream, and keeps running error statistics for approximate-Dadda characterisation.

Parameters:
- WIDTH, 6, operand width; product width is 2*WIDTH.
- SETTLE, 2, number of cycles operands are held on the multiplier before sampling; legal range 0..15.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operand pair valid
- op_ready  out  1  block can accept an operand pair
- op_a  in  WIDTH  multiplicand
- op_b  in  WIDTH  multiplier
- mul_in1  out  WIDTH  drives if_multiplier in1
- mul_in2  out  WIDTH  drives if_multiplier in2
- mul_out  in  2*WIDTH  if_multiplier out (approximate product)
- mul_overflow  in  1  if_multiplier overflow
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_prod  out  2*WIDTH  sampled approximate product
- res_err  out  2*WIDTH+1  signed error, exact minus approximate
- res_ovf  out  1  sampled overflow flag
- stat_count  out  CNT_W  results produced
- stat_mismatch  out  CNT_W  results with res_err != 0
- stat_max_abs  out  2*WIDTH  largest |err| seen

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- FSM states: IDLE, DRIVE, SAMPLE, HOLD.
- Reset:
  - FSM goes to IDLE.
  - op_ready=1, res_valid=0.
  - mul_in1, mul_in2, res_prod, res_err, res_ovf are all 0.
  - All statistics are 0.
- IDLE:
  - op_ready=1.
  - On op_valid&op_ready, register op_a/op_b onto mul_in1/mul_in2, load the settle counter with SETTLE, and go to DRIVE.
  - If SETTLE=0, go directly to SAMPLE.
- DRIVE:
  - op_ready=0; mul_in1/mul_in2 held stable.
  - Settle counter decrements each cycle.
  - When the counter reaches 1, go to SAMPLE.
- SAMPLE, one cycle:
  - Capture mul_out into res_prod and mul_overflow into res_ovf.
  - res_err = zero-extended (op_a*op_b) minus zero-extended mul_out, computed in 2*WIDTH+1 bits, two's complement.
  - Update statistics.
  - Go to HOLD with res_valid=1.
- HOLD:
  - res_valid=1; res_prod/res_err/res_ovf remain stable until res_valid&res_ready.
  - On that handshake, res_valid falls the next cycle and the FSM goes to IDLE.
  - op_ready is 0 throughout HOLD; there is no overlap between operations.
- Latency: handshake at cycle 0 → res_valid at cycle max(SETTLE,1)+1.
- Throughput: one result per max(SETTLE,1)+2 cycles under continuous res_ready.
- Statistics:
  - All counters saturate at all-ones and never wrap.
  - stat_max_abs updates only when |err| > current value.
  - |err| of the most negative value fits in 2*WIDTH bits, because an unsigned difference cannot reach -2^(2*WIDTH).
- Reset mid-operation: aborts immediately, and the next cycle is in reset state. A partial operation is not counted.
- op_valid is ignored while op_ready=0. A source may drop op_valid without penalty.

Optional Feature:
- Macro: MUL_DRV_ERRSUM_EN.
- With the macro defined:
  - Adds output stat_err_sum, width CNT_W+2*WIDTH, holding the saturating sum of |err| over all results. Used for mean error distance.
  - Adds input stat_clr, 1 bit. Its pulse zeroes every statistic on the next cycle.
  - stat_clr takes priority over a coincident SAMPLE update; that sample is not counted.
- Without the macro: neither port exists, and statistics clear only on rst.

Decomposition:
- Shared package mul_drv_pkg holds:
  - the FSM state enum (IDLE, DRIVE, SAMPLE, HOLD);
  - localparam functions for the product width and error width.
- Add a drv_side modport to if_multiplier that mirrors mul_side. Top-level ports map onto it.
- One natural sub-module: mul_err_stats. It takes the sample strobe and err, and owns all saturating counters and the max tracker. It contains the optional MUL_DRV_ERRSUM_EN logic.

Test Plan:
- WIDTH=6, SETTLE=2, exact stub multiplier, op 7×9 → res_valid at cycle 3, res_prod=63, res_err=0, stat_count=1, stat_mismatch=0.
- Stub returns 3968 for 63×63 → res_err=+1, stat_mismatch=1, stat_max_abs=1. A second op 5×5 with stub returning 27 → res_err=-2, stat_max_abs=2.
- Hold res_ready low for 5 cycles after res_valid → res_* stable, op_ready=0, op_valid pulses ignored. Raise res_ready → op_ready=1 one cycle later.
- SETTLE=0, back-to-back ops with res_ready=1 → result every 3 cycles, each matching its own operands.
- Assert rst in DRIVE → next cycle IDLE, op_ready=1, res_valid=0, stat_count unchanged from 0.
- Force stat_count near all-ones (CNT_W=4, 20 ops) → stat_count saturates at 15. With MUL_DRV_ERRSUM_EN, a stat_clr pulse zeroes all statistics, including stat_err_sum.
